// File: rtl/lock_pkg.sv
// Shared keypad codes, lock state encoding and key classification helper.
package lock_pkg;

  localparam logic [3:0] KEY_NONE = 4'd15;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd12;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    PROGRAM  = 2'd2,
    LOCKOUT  = 2'd3
  } lock_state_t;

  // Digits 0-9 are the only codes that enter the code buffer.
  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage

// File: rtl/code_entry_buf.sv
// BCD entry buffer: shifts digits in (newest in the LS nibble) until full,
// then drops further digits. Clear has priority over a digit.
module code_entry_buf
  import lock_pkg::*;
#(
  parameter int CODE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  digit_en,
  input  logic [3:0]            digit,
  output logic [4*CODE_LEN-1:0] digits,
  output logic [2:0]            count,
  output logic                  full
);

  logic [4*CODE_LEN-1:0] digits_r;
  logic [4*CODE_LEN-1:0] shifted_s;
  logic [2:0]            count_r;
  logic                  full_s;

  generate
    if (CODE_LEN == 1) begin : g_single
      assign shifted_s = digit;
    end else begin : g_multi
      assign shifted_s = {digits_r[4*CODE_LEN-5:0], digit};
    end
  endgenerate

  assign full_s = (count_r >= 3'(CODE_LEN));

  // Buffer register: clear, or accept a digit while not yet full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_r <= '0;
      count_r  <= 3'd0;
    end else if (clear) begin
      digits_r <= '0;
      count_r  <= 3'd0;
    end else if (digit_en && !full_s) begin
      digits_r <= shifted_s;
      count_r  <= count_r + 3'd1;
    end
  end

  assign digits = digits_r;
  assign count  = count_r;
  assign full   = full_s;

endmodule

// File: rtl/code_lock_ctrl.sv
// Password-lock controller: entry compare, auto-relock timer, failure
// lockout with alarm, and volatile code reprogramming.
module code_lock_ctrl
  import lock_pkg::*;
#(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    UNLOCK_CYCLES  = 60_000_000,
  parameter int                    LOCKOUT_CYCLES = 360_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            key_code,
  output logic                  unlocked,
  output logic                  alarm,
  output logic                  prog_mode,
  output logic [1:0]            fail_cnt,
  output logic [2:0]            entry_cnt,
  output logic [4*CODE_LEN-1:0] entry_digits,
  output logic                  err_pulse
);

  localparam int TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  // Loaded with N-1 so the timed state lasts exactly N cycles (N-1 .. 0).
  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO   = {TIMER_W{1'b0}};
  localparam logic [1:0]         MAX_FAIL     = 2'(MAX_TRIES);

  lock_state_t           state_r, next_s;
  logic [TIMER_W-1:0]    timer_r, timer_next_s;
  logic [4*CODE_LEN-1:0] code_r, code_next_s;
  logic [1:0]            fail_r, fail_next_s, fail_inc_s;
  logic                  err_s, clear_req_s, buf_clear_s, buf_digit_en_s;
  logic                  unlocked_r, alarm_r, prog_r, err_r;
  logic                  digit_key_s, star_s, hash_s, timer_zero_s;
  logic [4*CODE_LEN-1:0] buf_digits_s;
  logic [2:0]            buf_count_s;
  logic                  buf_full_s;

  assign digit_key_s  = is_digit(key_code);
  assign star_s       = (key_code == KEY_STAR);
  assign hash_s       = (key_code == KEY_HASH);
  assign timer_zero_s = (timer_r == TIMER_ZERO);
  assign fail_inc_s   = (fail_r >= MAX_FAIL) ? MAX_FAIL : fail_r + 2'd1;

  code_entry_buf #(.CODE_LEN(CODE_LEN)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (buf_clear_s),
    .digit_en (buf_digit_en_s),
    .digit    (key_code),
    .digits   (buf_digits_s),
    .count    (buf_count_s),
    .full     (buf_full_s)
  );

  // Next-state, timer, stored-code and failure-count decisions per key.
  always_comb begin
    next_s         = state_r;
    timer_next_s   = timer_r;
    code_next_s    = code_r;
    fail_next_s    = fail_r;
    err_s          = 1'b0;
    clear_req_s    = 1'b0;
    buf_digit_en_s = 1'b0;
    case (state_r)
      LOCKED: begin
        if (digit_key_s) begin
          buf_digit_en_s = 1'b1;
        end else if (star_s) begin
          clear_req_s = 1'b1;
        end else if (hash_s) begin
          if (buf_full_s && (buf_digits_s == code_r)) begin
            next_s       = UNLOCKED;
            fail_next_s  = 2'd0;
            timer_next_s = UNLOCK_LOAD;
          end else begin
            err_s       = 1'b1;
            fail_next_s = fail_inc_s;
            clear_req_s = 1'b1;
            if (fail_inc_s == MAX_FAIL) begin
              next_s       = LOCKOUT;
              timer_next_s = LOCKOUT_LOAD;
            end else begin
              next_s = LOCKED;
            end
          end
        end else begin
          next_s = LOCKED;
        end
      end
      UNLOCKED: begin
        if (timer_zero_s) begin
          next_s = LOCKED;
        end else begin
          timer_next_s = timer_r - 1'b1;
          if (star_s) begin
            next_s = LOCKED;
          end else if (hash_s) begin
            next_s       = PROGRAM;
            timer_next_s = UNLOCK_LOAD;
          end else begin
            next_s = UNLOCKED;
          end
        end
      end
      PROGRAM: begin
        if (timer_zero_s) begin
          next_s = LOCKED;
        end else begin
          timer_next_s = timer_r - 1'b1;
          if (digit_key_s) begin
            buf_digit_en_s = 1'b1;
            timer_next_s   = UNLOCK_LOAD;
          end else if (star_s) begin
            clear_req_s = 1'b1;
          end else if (hash_s) begin
            if (buf_full_s) begin
              code_next_s = buf_digits_s;
              next_s      = LOCKED;
            end else begin
              err_s       = 1'b1;
              clear_req_s = 1'b1;
            end
          end else begin
            next_s = PROGRAM;
          end
        end
      end
      LOCKOUT: begin
        if (timer_zero_s) begin
          next_s      = LOCKED;
          fail_next_s = 2'd0;
        end else begin
          timer_next_s = timer_r - 1'b1;
        end
      end
      default: begin
        next_s       = LOCKED;
        timer_next_s = TIMER_ZERO;
      end
    endcase
    if (next_s == LOCKED) begin
      timer_next_s = TIMER_ZERO;
    end else begin
      timer_next_s = timer_next_s;
    end
  end

  // Any state change empties the entry buffer.
  assign buf_clear_s = clear_req_s || (next_s != state_r);

  // State, timer, stored code, failure count and registered output decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= LOCKED;
      timer_r    <= TIMER_ZERO;
      code_r     <= DEFAULT_CODE;
      fail_r     <= 2'd0;
      unlocked_r <= 1'b0;
      alarm_r    <= 1'b0;
      prog_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= next_s;
      timer_r    <= timer_next_s;
      code_r     <= code_next_s;
      fail_r     <= fail_next_s;
      unlocked_r <= (next_s == UNLOCKED);
      alarm_r    <= (next_s == LOCKOUT);
      prog_r     <= (next_s == PROGRAM);
      err_r      <= err_s;
    end
  end

  assign unlocked     = unlocked_r;
  assign alarm        = alarm_r;
  assign prog_mode    = prog_r;
  assign fail_cnt     = fail_r;
  assign entry_cnt    = buf_count_s;
  assign entry_digits = buf_digits_s;
  assign err_pulse    = err_r;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with short timers (unlock 20, lockout 50).
module tb_code_lock_ctrl;
  import lock_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_code = 4'd15;
  logic        unlocked, alarm, prog_mode, err_pulse;
  logic [1:0]  fail_cnt;
  logic [2:0]  entry_cnt;
  logic [15:0] entry_digits;
  int total = 0;
  int bad = 0;

  code_lock_ctrl #(
    .CODE_LEN(4), .DEFAULT_CODE(16'h1234), .MAX_TRIES(3),
    .UNLOCK_CYCLES(20), .LOCKOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code),
    .unlocked(unlocked), .alarm(alarm), .prog_mode(prog_mode),
    .fail_cnt(fail_cnt), .entry_cnt(entry_cnt),
    .entry_digits(entry_digits), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  // Called at a negedge; presents the key for one cycle and returns at the
  // negedge right after the sampling edge.
  task automatic press(input logic [3:0] k);
    key_code = k;
    @(negedge clk);
    key_code = 4'd15;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    key_code = 4'd15;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic enter_1234_hash();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_HASH);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick(2);
    total++;
    if ({unlocked, alarm, prog_mode, err_pulse, fail_cnt, entry_cnt, entry_digits} !== 25'd0) begin
      $display("FAIL reset_outputs got u=%0d a=%0d p=%0d e=%0d f=%0d n=%0d d=%h want all 0",
               unlocked, alarm, prog_mode, err_pulse, fail_cnt, entry_cnt, entry_digits);
      bad++;
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_unlock_relock();
    apply_reset();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    total++;
    if (entry_digits !== 16'h1234 || entry_cnt !== 3'd4) begin
      $display("FAIL t1_buffer got d=%h n=%0d want d=1234 n=4", entry_digits, entry_cnt);
      bad++;
    end
    press(KEY_HASH);
    total++;
    if (unlocked !== 1'b1 || fail_cnt !== 2'd0 || entry_cnt !== 3'd0) begin
      $display("FAIL t1_unlock got u=%0d f=%0d n=%0d want u=1 f=0 n=0", unlocked, fail_cnt, entry_cnt);
      bad++;
    end
    tick(19);
    total++;
    if (unlocked !== 1'b1) begin
      $display("FAIL t1_still_open got u=%0d want 1", unlocked);
      bad++;
    end
    tick(1);
    total++;
    if (unlocked !== 1'b0 || entry_cnt !== 3'd0) begin
      $display("FAIL t1_relock got u=%0d n=%0d want u=0 n=0", unlocked, entry_cnt);
      bad++;
    end
  endtask

  task automatic test_wrong_code();
    apply_reset();
    press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(KEY_HASH);
    total++;
    if (err_pulse !== 1'b1 || fail_cnt !== 2'd1 || unlocked !== 1'b0) begin
      $display("FAIL t2_wrong got e=%0d f=%0d u=%0d want e=1 f=1 u=0", err_pulse, fail_cnt, unlocked);
      bad++;
    end
    tick(1);
    total++;
    if (err_pulse !== 1'b0) begin
      $display("FAIL t2_pulse_width got e=%0d want 0", err_pulse);
      bad++;
    end
    press(4'd1); press(4'd2); press(KEY_HASH);
    total++;
    if (fail_cnt !== 2'd2 || err_pulse !== 1'b1) begin
      $display("FAIL t2_short got f=%0d e=%0d want f=2 e=1", fail_cnt, err_pulse);
      bad++;
    end
  endtask

  task automatic test_lockout();
    apply_reset();
    press(KEY_HASH); press(KEY_HASH); press(KEY_HASH);
    total++;
    if (alarm !== 1'b1 || fail_cnt !== 2'd3) begin
      $display("FAIL t3_lockout got a=%0d f=%0d want a=1 f=3", alarm, fail_cnt);
      bad++;
    end
    enter_1234_hash();
    total++;
    if (alarm !== 1'b1 || unlocked !== 1'b0 || entry_cnt !== 3'd0 || fail_cnt !== 2'd3) begin
      $display("FAIL t3_ignored got a=%0d u=%0d n=%0d f=%0d want a=1 u=0 n=0 f=3",
               alarm, unlocked, entry_cnt, fail_cnt);
      bad++;
    end
    tick(44);
    total++;
    if (alarm !== 1'b1) begin
      $display("FAIL t3_alarm_held got a=%0d want 1", alarm);
      bad++;
    end
    tick(1);
    total++;
    if (alarm !== 1'b0 || fail_cnt !== 2'd0) begin
      $display("FAIL t3_release got a=%0d f=%0d want a=0 f=0", alarm, fail_cnt);
      bad++;
    end
    enter_1234_hash();
    total++;
    if (unlocked !== 1'b1) begin
      $display("FAIL t3_unlock_after got u=%0d want 1", unlocked);
      bad++;
    end
  endtask

  task automatic test_program();
    apply_reset();
    enter_1234_hash();
    press(KEY_HASH);
    total++;
    if (prog_mode !== 1'b1 || unlocked !== 1'b0) begin
      $display("FAIL t4_enter_prog got p=%0d u=%0d want p=1 u=0", prog_mode, unlocked);
      bad++;
    end
    press(4'd5); press(KEY_HASH);
    total++;
    if (err_pulse !== 1'b1 || prog_mode !== 1'b1 || entry_cnt !== 3'd0) begin
      $display("FAIL t4_prog_short got e=%0d p=%0d n=%0d want e=1 p=1 n=0", err_pulse, prog_mode, entry_cnt);
      bad++;
    end
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    total++;
    if (entry_digits !== 16'h9876) begin
      $display("FAIL t4_prog_buf got %h want 9876", entry_digits);
      bad++;
    end
    press(KEY_HASH);
    total++;
    if (prog_mode !== 1'b0 || unlocked !== 1'b0 || alarm !== 1'b0) begin
      $display("FAIL t4_commit got p=%0d u=%0d a=%0d want 0 0 0", prog_mode, unlocked, alarm);
      bad++;
    end
    enter_1234_hash();
    total++;
    if (unlocked !== 1'b0 || err_pulse !== 1'b1 || fail_cnt !== 2'd1) begin
      $display("FAIL t4_old_code got u=%0d e=%0d f=%0d want u=0 e=1 f=1", unlocked, err_pulse, fail_cnt);
      bad++;
    end
    press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(KEY_HASH);
    total++;
    if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin
      $display("FAIL t4_new_code got u=%0d f=%0d want u=1 f=0", unlocked, fail_cnt);
      bad++;
    end
    apply_reset();
    enter_1234_hash();
    total++;
    if (unlocked !== 1'b1) begin
      $display("FAIL t4_reset_default got u=%0d want 1", unlocked);
      bad++;
    end
  endtask

  task automatic test_star_overflow();
    apply_reset();
    press(4'd1); press(4'd2); press(4'd11); press(4'd13); press(4'd14);
    total++;
    if (entry_cnt !== 3'd2 || entry_digits !== 16'h0012) begin
      $display("FAIL t5_ignored_keys got n=%0d d=%h want n=2 d=0012", entry_cnt, entry_digits);
      bad++;
    end
    press(KEY_STAR);
    total++;
    if (entry_cnt !== 3'd0 || entry_digits !== 16'h0000) begin
      $display("FAIL t5_star got n=%0d d=%h want n=0 d=0000", entry_cnt, entry_digits);
      bad++;
    end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    total++;
    if (entry_cnt !== 3'd4 || entry_digits !== 16'h1234) begin
      $display("FAIL t5_overflow got n=%0d d=%h want n=4 d=1234", entry_cnt, entry_digits);
      bad++;
    end
    press(KEY_HASH);
    total++;
    if (unlocked !== 1'b1) begin
      $display("FAIL t5_unlock got u=%0d want 1", unlocked);
      bad++;
    end
  endtask

  task automatic test_expiry_vs_key();
    apply_reset();
    enter_1234_hash();
    tick(19);
    press(KEY_HASH);
    total++;
    if (unlocked !== 1'b0 || prog_mode !== 1'b0 || err_pulse !== 1'b0) begin
      $display("FAIL t6_expiry_wins got u=%0d p=%0d e=%0d want 0 0 0", unlocked, prog_mode, err_pulse);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_unlock_relock();
    test_wrong_code();
    test_lockout();
    test_program();
    test_star_overflow();
    test_expiry_vs_key();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
